// File: rtl/ser_deser_pkg.sv
// Shared types and defaults for the serial frame deserializer.
package ser_deser_pkg;

  typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

  localparam int          DEF_DATA_W   = 8;
  localparam int          DEF_SYNC_W   = 8;
  localparam logic [7:0]  DEF_SYNC_PAT = 8'hA5;

  // Width of a counter that must reach DATA_W.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/ser_out_buf.sv
// One-entry valid/ready holding register for received words.
module ser_out_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  output logic              full
);

  // Full means a word is held and is not leaving on this edge.
  assign full = dvalid & ~ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dvalid <= 1'b0;
      dout   <= '0;
    end else if (load) begin
      dvalid <= 1'b1;
      dout   <= load_data;
    end else if (dvalid && ready) begin
      dvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/ser_frame_deser.sv
// Sync-hunting serial deserializer with even parity check, line-fault
// detection on the true/complement pair, and a one-word output buffer.
module ser_frame_deser
  import ser_deser_pkg::*;
#(
  parameter int               DATA_W   = DEF_DATA_W,
  parameter int               SYNC_W   = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(DEF_SYNC_PAT)
) (
  input  logic              CLK2,
  input  logic              RST,
  input  logic              EN,
  input  logic              SDI,
  input  logic              SDI_B,
  output logic [DATA_W-1:0] DOUT,
  output logic              DVALID,
  input  logic              DREADY,
  output logic              PERR,
  output logic              OVR,
  output logic              LERR
);

  localparam int CW = cnt_w(DATA_W);

  state_t              state;
  logic [SYNC_W-1:0]   window;
  logic [SYNC_W-1:0]   window_next;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   shreg;
  logic                line_bad;
  logic                good;
  logic                full;
  logic                load;

  function automatic logic parity_ok(input logic [DATA_W-1:0] d, input logic p);
    return ~(^d ^ p);
  endfunction

  assign window_next = {window[SYNC_W-2:0], SDI};
  assign line_bad    = (SDI == SDI_B);
  assign good        = parity_ok(shreg, SDI);
  assign load        = EN && !line_bad && (state == PARITY) && good && !full;

  // Receive FSM: line check outranks every state action.
  always_ff @(posedge CLK2) begin
    if (RST) begin
      state  <= HUNT;
      window <= '0;
      cnt    <= '0;
      shreg  <= '0;
      PERR   <= 1'b0;
      OVR    <= 1'b0;
      LERR   <= 1'b0;
    end else begin
      PERR <= 1'b0;
      OVR  <= 1'b0;
      LERR <= 1'b0;
      if (EN) begin
        if (line_bad) begin
          LERR   <= 1'b1;
          state  <= HUNT;
          window <= '0;
        end else begin
          case (state)
            HUNT: begin
              window <= window_next;
              if (window_next == SYNC_PAT) begin
                state <= DATA;
                cnt   <= '0;
              end
            end
            DATA: begin
              shreg <= {shreg[DATA_W-2:0], SDI};
              cnt   <= cnt + 1'b1;
              if (cnt == CW'(DATA_W - 1)) state <= PARITY;
            end
            PARITY: begin
              if (!good)     PERR <= 1'b1;
              else if (full) OVR  <= 1'b1;
              // Fresh sync required: nothing from this frame may seed the window.
              state  <= HUNT;
              window <= '0;
            end
            default: begin
              state  <= HUNT;
              window <= '0;
            end
          endcase
        end
      end
    end
  end

  ser_out_buf #(.DATA_W(DATA_W)) u_buf (
    .clk      (CLK2),
    .rst      (RST),
    .load     (load),
    .load_data(shreg),
    .ready    (DREADY),
    .dout     (DOUT),
    .dvalid   (DVALID),
    .full     (full)
  );

endmodule

// File: tb/tb_ser_frame_deser.sv
// Randomized bench for ser_frame_deser against a bit-queue reference model.
module tb_ser_frame_deser;

  logic       clk = 1'b0;
  logic       rst, en, sdi, sdi_b, dready;
  logic [7:0] dout;
  logic       dvalid, perr, ovr, lerr;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         m_hunting = 1'b1;
  bit         m_q[$];
  logic [7:0] m_dout  = '0;
  logic       m_valid = 1'b0;
  logic       m_perr, m_ovr, m_lerr;

  bit rnd_rdy = 1'b0;
  int gaps    = 0;

  ser_frame_deser dut (
    .CLK2  (clk),
    .RST   (rst),
    .EN    (en),
    .SDI   (sdi),
    .SDI_B (sdi_b),
    .DOUT  (dout),
    .DVALID(dvalid),
    .DREADY(dready),
    .PERR  (perr),
    .OVR   (ovr),
    .LERR  (lerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic r, input logic e, input logic d, input logic db);
    bit         ld;
    logic [7:0] w;
    int         ones;
    int         pat;
    @(negedge clk);
    rst = r; en = e; sdi = d; sdi_b = db;
    if (rnd_rdy) dready = ($urandom_range(0, 2) != 0);
    m_perr = 0; m_ovr = 0; m_lerr = 0; ld = 0; w = '0;
    if (r) begin
      m_hunting = 1; m_q.delete(); m_valid = 0; m_dout = '0;
    end else begin
      if (e) begin
        if (d == db) begin
          m_lerr = 1; m_hunting = 1; m_q.delete();
        end else if (m_hunting) begin
          m_q.push_back(d);
          if (m_q.size() > 8) void'(m_q.pop_front());
          pat = 0;
          foreach (m_q[i]) pat = pat * 2 + int'(m_q[i]);
          if (m_q.size() == 8 && pat == 'hA5) begin
            m_hunting = 0; m_q.delete();
          end
        end else begin
          m_q.push_back(d);
          if (m_q.size() == 9) begin
            ones = 0;
            for (int i = 0; i < 8; i++) begin
              w = {w[6:0], logic'(m_q[i])};
              ones += int'(m_q[i]);
            end
            ones += int'(m_q[8]);
            if (ones % 2 != 0)           m_perr = 1;
            else if (m_valid && !dready) m_ovr  = 1;
            else                         ld     = 1;
            m_hunting = 1; m_q.delete();
          end
        end
      end
      if (ld) begin
        m_dout = w; m_valid = 1;
      end else if (m_valid && dready) begin
        m_valid = 0;
      end
    end
    @(posedge clk); #1;
    chk("dvalid", dvalid, m_valid);
    chk("dout",   dout,   m_dout);
    chk("perr",   perr,   m_perr);
    chk("ovr",    ovr,    m_ovr);
    chk("lerr",   lerr,   m_lerr);
  endtask

  task automatic send_bit(input logic b);
    for (int g = 0; g < gaps; g++) step(0, 0, 1'($urandom), 1'($urandom));
    step(0, 1, b, ~b);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    send_bits(8'hA5, 8);
    send_bits(d, 8);
    send_bit(p);
  endtask

  initial begin
    rst = 1; en = 0; sdi = 0; sdi_b = 1; dready = 1;

    // Reset with noise on the line
    step(1, 1'($urandom), 1'($urandom), 1'($urandom));
    step(1, 1'($urandom), 1'($urandom), 1'($urandom));
    chk("rst_dvalid", dvalid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_err", {perr, ovr, lerr}, 0);

    // Nominal frame
    send_frame(8'h3C, 1'b0);
    chk("nom_dvalid", dvalid, 1);
    chk("nom_dout", dout, 8'h3C);
    step(0, 0, 0, 1);
    chk("nom_drain", dvalid, 0);

    // Parity error then recovery
    send_frame(8'h3C, 1'b1);
    chk("par_perr", perr, 1);
    chk("par_dvalid", dvalid, 0);
    send_frame(8'h81, 1'b0);
    chk("par_next", dout, 8'h81);

    // Overrun with consumer stalled
    step(0, 0, 0, 1);
    dready = 0;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    chk("ovr_pulse", ovr, 1);
    chk("ovr_hold", dout, 8'h01);
    dready = 1;
    step(0, 0, 0, 1);
    chk("ovr_drain", dvalid, 0);

    // Line fault on the 4th data bit
    send_bits(8'hA5, 8);
    send_bits(8'h5A, 3);
    step(0, 1, 1, 1);
    chk("line_lerr", lerr, 1);
    send_bits(8'h5A, 4);
    send_bit(1'b0);
    chk("line_nodv", dvalid, 0);
    send_frame(8'h5A, 1'b0);
    chk("line_next", dout, 8'h5A);

    // Strobe gaps between every bit
    gaps = 3;
    send_frame(8'h3C, 1'b0);
    chk("gap_dout", dout, 8'h3C);
    gaps = 0;

    // Reset mid-frame, then the tail must not complete a frame
    send_bits(8'hA5, 8);
    send_bits(8'hC3, 4);
    step(1, 1, 0, 1);
    send_bits(8'h0F, 4);
    send_bit(1'b0);
    chk("rst_mid", dvalid, 0);
    send_frame(8'h96, 1'b0);
    chk("rst_rehunt", dout, 8'h96);

    // Randomized frames with noise, gaps, bad parity, line faults and back-pressure
    rnd_rdy = 1;
    for (int f = 0; f < 200; f++) begin
      logic [7:0] d;
      logic       p;
      int         noise;
      d = 8'($urandom);
      p = ^d;
      if ($urandom_range(0, 4) == 0) p = ~p;
      gaps = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      noise = $urandom_range(0, 6);
      for (int k = 0; k < noise; k++) begin
        logic b;
        b = 1'($urandom);
        step(0, 1'($urandom), b, ($urandom_range(0, 15) == 0) ? b : ~b);
      end
      send_bits(8'hA5, 8);
      if ($urandom_range(0, 9) == 0) begin
        int cut;
        cut = $urandom_range(0, 7);
        send_bits(d, cut);
        step(0, 1, 1'($urandom), sdi);
        send_bits(d, 8 - cut);
      end else begin
        send_bits(d, 8);
      end
      send_bit(p);
    end
    rnd_rdy = 0;
    gaps = 0;
    dready = 1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
